pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipeline_hazard_ctrl
// Brief  : 5-stage in-order pipeline stall/flush/forwarding control with
//          per-stage valid tracking and saturating stall/flush counters.
//          Define HAZARD_FORWARDING_EN to enable operand forwarding.
// Rev    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
   input  logic                      rs1_used_d,
   input  logic                      rs2_used_d,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
   input  logic [REG_ADDR_WIDTH-1:0] rd_e,
   input  logic [REG_ADDR_WIDTH-1:0] rd_m,
   input  logic [REG_ADDR_WIDTH-1:0] rd_w,
   input  logic                      reg_wr_en_e,
   input  logic                      reg_wr_en_m,
   input  logic                      reg_wr_en_w,
   input  logic                      load_e,
   input  logic                      load_m,
   input  logic                      branch_taken_e,
   output logic                      pc_wr_en,
   output logic                      if_id_wr_en,
   output logic                      pc_sel_target,
   output logic                      valid_d,
   output logic                      valid_e,
   output logic                      valid_m,
   output logic                      valid_w,
   output logic [1:0]                fwd_a_sel,
   output logic [1:0]                fwd_b_sel,
   output logic [1:0]                ctrl_state,
   output logic [CNT_WIDTH-1:0]      stall_cnt,
   output logic [CNT_WIDTH-1:0]      flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic                  vld_d_q, vld_e_q, vld_m_q, vld_w_q;
   logic                  vld_d_d, vld_e_d, vld_m_d, vld_w_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

   logic src_e, src_m, src_w;
   logic hit_e, hit_m, hit_w;
   logic hazard, stall, flush;

   // A stage can only produce a hazard if it is live and really writes a non-x0 register.
   assign src_e = vld_e_q & reg_wr_en_e & (rd_e != '0);
   assign src_m = vld_m_q & reg_wr_en_m & (rd_m != '0);
   assign src_w = vld_w_q & reg_wr_en_w & (rd_w != '0);

   assign hit_e = (rs1_used_d & (rs1_d == rd_e)) | (rs2_used_d & (rs2_d == rd_e));
   assign hit_m = (rs1_used_d & (rs1_d == rd_m)) | (rs2_used_d & (rs2_d == rd_m));
   assign hit_w = (rs1_used_d & (rs1_d == rd_w)) | (rs2_used_d & (rs2_d == rd_w));

`ifdef HAZARD_FORWARDING_EN
   assign hazard = src_e & load_e & hit_e;

   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (rs1_e != '0) begin
         if (src_m & ~load_m & (rs1_e == rd_m))  fwd_a_sel = 2'b01;
         else if (src_w & (rs1_e == rd_w))       fwd_a_sel = 2'b10;
      end
      if (rs2_e != '0) begin
         if (src_m & ~load_m & (rs2_e == rd_m))  fwd_b_sel = 2'b01;
         else if (src_w & (rs2_e == rd_w))       fwd_b_sel = 2'b10;
      end
   end
`else
   assign hazard    = (src_e & hit_e) | (src_m & hit_m) | (src_w & hit_w);
   assign fwd_a_sel = 2'b00;
   assign fwd_b_sel = 2'b00;

   logic unused_ok;
   assign unused_ok = &{1'b0, rs1_e, rs2_e, load_e, load_m};
`endif

   assign flush         = branch_taken_e & vld_e_q;
   assign stall         = vld_d_q & hazard & ~flush;
   assign pc_sel_target = flush;
   assign pc_wr_en      = ~stall;
   assign if_id_wr_en   = ~stall;

   always_comb begin
      vld_d_d = 1'b1;
      vld_e_d = vld_d_q;
      vld_m_d = vld_e_q;
      vld_w_d = vld_m_q;
      state_d = ST_RUN;
      if (flush) begin
         vld_d_d = 1'b0;
         vld_e_d = 1'b0;
         state_d = ST_FLUSH;
      end else if (stall) begin
         vld_d_d = vld_d_q;
         vld_e_d = 1'b0;
         state_d = ST_STALL;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         vld_d_q     <= 1'b0;
         vld_e_q     <= 1'b0;
         vld_m_q     <= 1'b0;
         vld_w_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         vld_d_q     <= vld_d_d;
         vld_e_q     <= vld_e_d;
         vld_m_q     <= vld_m_d;
         vld_w_q     <= vld_w_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign valid_d    = vld_d_q;
   assign valid_e    = vld_e_q;
   assign valid_m    = vld_m_q;
   assign valid_w    = vld_w_q;
   assign ctrl_state = state_q;
   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;

endmodule
`default_nettype wire
